// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions.
//   DPW             datapath width
//   DMEM_DEPTH_DEF  default data-memory depth in 32-bit words
//   mem_state_t     memory-access FSM states of mem_wb_stage
package rv32i_pkg;

    localparam int DPW            = 32;
    localparam int DMEM_DEPTH_DEF = 256;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Data memory for the M stage: DEPTH x DPW words, synchronous write,
// combinational read. The array is deliberately not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable (written on the rising edge)
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data at addr (combinational)
module data_mem
    import rv32i_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [DPW-1:0] wdata,
    output logic [DPW-1:0] rdata
);

    logic [DPW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory + write-back end of the RV32I pipeline. Performs data-memory
// loads/stores with MEM_LAT wait states and drives the register-file
// write port.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no access in flight; non-memops and MEM_LAT=0 ops complete
//   ACCESS | memop waiting out its latency; completes when cnt == 0
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   validM, regwriteM,          M-stage bundle from execute
//   resultsrcM, memwriteM,
//   aluresultM, Rd2M, RdM
//   stallM                      M op cannot complete this cycle
//   we, addr_3, wd_3            registered register-file write port
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int ADW        = 5,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int MEM_LAT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           validM,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [ADW-1:0] RdM,
    output logic           stallM,
    output logic           we,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3
);

    localparam int         AW      = $clog2(DMEM_DEPTH);
    localparam bit         HAS_LAT = (MEM_LAT > 0);
    localparam logic [2:0] LAT_M1  = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

    mem_state_t     state, state_d;
    logic [2:0]     cnt, cnt_d;
    logic           memop, in_range, completing, stall, mem_we;
    logic [DPW-1:0] rdata, memdata;
    logic           we_q;
    logic [ADW-1:0] addr_q;
    logic [DPW-1:0] wd_q;
    logic           unused_byte_bits;

    assign memop    = validM & (resultsrcM | memwriteM);
    // Any address bit above the word index set means the access is off the end.
    assign in_range = ((aluresultM >> (AW + 2)) == '0);
    assign unused_byte_bits = ^aluresultM[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        completing = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (memop && HAS_LAT) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    stall   = 1'b1;
                end else begin
                    completing = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt != 3'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt - 3'd1;
                end else begin
                    completing = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stallM = stall;
    assign mem_we = completing & memop & memwriteM & in_range;

    data_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (aluresultM[AW+1:2]),
        .wdata (Rd2M),
        .rdata (rdata)
    );

    assign memdata = in_range ? rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            // Stores never write the register file, even if also flagged as a load.
            we_q <= completing & validM & regwriteM & (RdM != '0) & ~memwriteM;
            if (completing) begin
                addr_q <= RdM;
                wd_q   <= resultsrcM ? memdata : aluresultM;
            end
        end
    end

    assign we     = we_q;
    assign addr_3 = addr_q;
    assign wd_3   = wd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: MEM_LAT=2, instance b: MEM_LAT=0
    logic           a_validM = 0, a_regwriteM = 0, a_resultsrcM = 0, a_memwriteM = 0;
    logic [31:0]    a_alu = 0, a_rd2 = 0;
    logic [4:0]     a_rd = 0;
    logic           a_stallM, a_we;
    logic [4:0]     a_addr3;
    logic [31:0]    a_wd3;

    logic           b_validM = 0, b_regwriteM = 0, b_resultsrcM = 0, b_memwriteM = 0;
    logic [31:0]    b_alu = 0, b_rd2 = 0;
    logic [4:0]     b_rd = 0;
    logic           b_stallM, b_we;
    logic [4:0]     b_addr3;
    logic [31:0]    b_wd3;

    mem_wb_stage #(.ADW(5), .DMEM_DEPTH(256), .MEM_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .validM(a_validM), .regwriteM(a_regwriteM),
        .resultsrcM(a_resultsrcM), .memwriteM(a_memwriteM), .aluresultM(a_alu),
        .Rd2M(a_rd2), .RdM(a_rd), .stallM(a_stallM), .we(a_we), .addr_3(a_addr3), .wd_3(a_wd3));

    mem_wb_stage #(.ADW(5), .DMEM_DEPTH(256), .MEM_LAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .validM(b_validM), .regwriteM(b_regwriteM),
        .resultsrcM(b_resultsrcM), .memwriteM(b_memwriteM), .aluresultM(b_alu),
        .Rd2M(b_rd2), .RdM(b_rd), .stallM(b_stallM), .we(b_we), .addr_3(b_addr3), .wd_3(b_wd3));

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t sb[$];
    logic [31:0] mdl [2][256];
    int checks = 0;
    int errors = 0;

    // Drive one M-stage op into instance sel, wait out its stalls, check the W result.
    task automatic op(input bit sel, input bit v, input bit rw, input bit rs, input bit mw,
                      input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd);
        bit          memop, done, inr, exp_we, st, we_o;
        int          n, exp_stall;
        logic [31:0] mdata, exp_wd, wd_o;
        logic [4:0]  addr_o;
        wr_t         e;
        if (sel) begin
            b_validM = v; b_regwriteM = rw; b_resultsrcM = rs; b_memwriteM = mw;
            b_alu = alu; b_rd2 = rd2; b_rd = rd;
        end else begin
            a_validM = v; a_regwriteM = rw; a_resultsrcM = rs; a_memwriteM = mw;
            a_alu = alu; a_rd2 = rd2; a_rd = rd;
        end
        memop = v & (rs | mw);
        exp_stall = (memop && !sel) ? 2 : 0;
        inr = (alu < 32'd1024);
        mdata = inr ? mdl[sel][alu[9:2]] : 32'd0;
        if (memop && mw && inr) mdl[sel][alu[9:2]] = rd2;
        exp_we = v & rw & (rd != 0) & ~mw;
        exp_wd = rs ? mdata : alu;
        if (exp_we) begin
            e.a = rd; e.d = exp_wd;
            sb.push_back(e);
        end
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            st = sel ? b_stallM : a_stallM;
            if (st) n++; else done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stall_timeout sel=%0d alu=%h still stalling after 20 cycles", sel, alu);
        end
        checks++;
        if (n !== exp_stall) begin
            errors++;
            $display("FAIL stall_count sel=%0d alu=%h got %0d expected %0d", sel, alu, n, exp_stall);
        end
        @(posedge clk); #1;
        we_o   = sel ? b_we : a_we;
        addr_o = sel ? b_addr3 : a_addr3;
        wd_o   = sel ? b_wd3 : a_wd3;
        checks++;
        if (we_o !== exp_we) begin
            errors++;
            $display("FAIL we sel=%0d rd=%0d got %b expected %b", sel, rd, we_o, exp_we);
        end
        if (we_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty sel=%0d unexpected write addr=%0d data=%h", sel, addr_o, wd_o);
            end else begin
                e = sb.pop_front();
                if (addr_o !== e.a || wd_o !== e.d) begin
                    errors++;
                    $display("FAIL wb_data sel=%0d got x%0d=%h expected x%0d=%h",
                             sel, addr_o, wd_o, e.a, e.d);
                end
            end
        end else if (exp_we) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (a_we !== 1'b0 || a_addr3 !== 5'd0 || a_wd3 !== 32'd0 || a_stallM !== 1'b0) begin
            errors++;
            $display("FAIL %s_a got we=%b addr=%0d wd=%h stall=%b expected all 0",
                     tag, a_we, a_addr3, a_wd3, a_stallM);
        end
        checks++;
        if (b_we !== 1'b0 || b_addr3 !== 5'd0 || b_wd3 !== 32'd0 || b_stallM !== 1'b0) begin
            errors++;
            $display("FAIL %s_b got we=%b addr=%0d wd=%h stall=%b expected all 0",
                     tag, b_we, b_addr3, b_wd3, b_stallM);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        op(0, 1, 1, 0, 0, 32'h1234, 32'h0, 5'd5);
        op(0, 1, 1, 0, 0, 32'h9999, 32'h0, 5'd0);
        op(0, 0, 1, 0, 0, 32'h7777, 32'h0, 5'd6);
    endtask

    task automatic test_store_load;
        op(0, 1, 0, 0, 1, 32'h40, 32'hCAFE_F00D, 5'd2);
        op(0, 1, 1, 1, 0, 32'h40, 32'h0, 5'd7);
        op(0, 1, 1, 1, 1, 32'h40, 32'h1357_9BDF, 5'd8);
        op(0, 1, 1, 1, 0, 32'h43, 32'h0, 5'd9);
    endtask

    task automatic test_reset_mid;
        op(0, 1, 0, 0, 1, 32'h10, 32'h1111_1111, 5'd0);
        op(0, 1, 1, 0, 0, 32'hABC, 32'h0, 5'd9);
        #2 rst_n = 1'b0;
        a_validM = 1'b0;
        #1 check_zero("reset_midrun");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // store of DEADBEEF aborted by reset while in ACCESS
        a_validM = 1; a_regwriteM = 0; a_resultsrcM = 0; a_memwriteM = 1;
        a_alu = 32'h10; a_rd2 = 32'hDEAD_BEEF; a_rd = 5'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_stallM !== 1'b1) begin
            errors++;
            $display("FAIL access_stall got %b expected 1", a_stallM);
        end
        rst_n = 1'b0;
        a_validM = 1'b0;
        #1 check_zero("reset_access");
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, 1, 1, 1, 0, 32'h10, 32'h0, 5'd6);
    endtask

    task automatic test_out_of_range;
        op(0, 1, 0, 0, 1, 32'h0, 32'h0000_0055, 5'd0);
        op(0, 1, 1, 1, 0, 32'h400, 32'h0, 5'd8);
        op(0, 1, 0, 0, 1, 32'h400, 32'h0000_0077, 5'd0);
        op(0, 1, 1, 1, 0, 32'h0, 32'h0, 5'd9);
        op(0, 1, 1, 1, 0, 32'h8000_0000, 32'h0, 5'd10);
    endtask

    task automatic test_back_to_back;
        op(0, 1, 0, 0, 1, 32'h8, 32'h1, 5'd0);
        op(0, 1, 1, 1, 0, 32'h8, 32'h0, 5'd3);
        op(0, 1, 1, 0, 0, 32'h4444, 32'h0, 5'd4);
        op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_mem_lat0;
        op(1, 1, 0, 0, 1, 32'h20, 32'h0000_A5A5, 5'd0);
        op(1, 1, 1, 1, 0, 32'h20, 32'h0, 5'd10);
        op(1, 1, 0, 0, 1, 32'h24, 32'h0000_5A5A, 5'd0);
        op(1, 1, 1, 1, 0, 32'h24, 32'h0, 5'd11);
        op(1, 1, 1, 1, 0, 32'h20, 32'h0, 5'd13);
        op(1, 1, 1, 0, 0, 32'h3333, 32'h0, 5'd12);
        op(1, 1, 1, 1, 0, 32'h400, 32'h0, 5'd14);
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 256; w++)
                mdl[s][w] = 32'd0;
        test_reset();
        test_alu();
        test_store_load();
        test_reset_mid();
        test_out_of_range();
        test_back_to_back();
        test_mem_lat0();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
